// File: rtl/instr_type_decoder_pkg.sv
// Shared types for the decode-stage front end.
// Opcode and ALU-op constants, buffer states and the decoded bundle.
package decoder_pkg;

  localparam int INSTR_W = 32;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] ALUOP_R       = 3'b000;
  localparam logic [2:0] ALUOP_I       = 3'b001;
  localparam logic [2:0] ALUOP_BRANCH  = 3'b010;
  localparam logic [2:0] ALUOP_JUMP    = 3'b011;
  localparam logic [2:0] ALUOP_LOAD    = 3'b100;
  localparam logic [2:0] ALUOP_STORE   = 3'b101;
  localparam logic [2:0] ALUOP_LUI     = 3'b110;
  localparam logic [2:0] ALUOP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               r_type;
    logic               i_type;
    logic               store;
    logic               load;
    logic               branch;
    logic               jal;
    logic               jalr;
    logic               lui;
    logic [2:0]         aluop;
    logic               illegal;
  } dec_t;

endpackage

// File: rtl/instr_type_decoder_if.sv
// Fetch-side and execute-side handshakes of the type decoder.
// slave is the decoder view, master the fetch/execute view.
interface instr_type_decoder_if;
  import decoder_pkg::*;

  logic [INSTR_W-1:0] instr_i;
  logic               instr_valid_i;
  logic               instr_ready_o;
  logic               flush_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [INSTR_W-1:0] instr_o;
  logic               r_type_o;
  logic               i_type_o;
  logic               store_o;
  logic               load_o;
  logic               branch_o;
  logic               jal_o;
  logic               jalr_o;
  logic               lui_o;
  logic [2:0]         aluop_o;
  logic               illegal_o;
  logic [31:0]        perf_cnt_o;

  modport slave (
    input  instr_i, instr_valid_i, flush_i, out_ready_i,
    output instr_ready_o, out_valid_o, instr_o,
    output r_type_o, i_type_o, store_o, load_o,
    output branch_o, jal_o, jalr_o, lui_o,
    output aluop_o, illegal_o, perf_cnt_o
  );

  modport master (
    output instr_i, instr_valid_i, flush_i, out_ready_i,
    input  instr_ready_o, out_valid_o, instr_o,
    input  r_type_o, i_type_o, store_o, load_o,
    input  branch_o, jal_o, jalr_o, lui_o,
    input  aluop_o, illegal_o, perf_cnt_o
  );

endinterface

// File: rtl/instr_type_decoder_opcode_classify.sv
// Combinational RV32I opcode classifier.
// Maps instr[6:0] to one-hot type strobes and the ALU op class.
module opcode_classify
  import decoder_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec
);

  logic [6:0] opc;

  assign opc = instr[6:0];

  always_comb begin
    dec       = '0;
    dec.instr = instr;
    unique case (1'b1)
      (opc == OPC_R): begin
        dec.r_type = 1'b1;
        dec.aluop  = ALUOP_R;
      end
      (opc == OPC_I): begin
        dec.i_type = 1'b1;
        dec.aluop  = ALUOP_I;
      end
      (opc == OPC_STORE): begin
        dec.store = 1'b1;
        dec.aluop = ALUOP_STORE;
      end
      (opc == OPC_LOAD): begin
        dec.load  = 1'b1;
        dec.aluop = ALUOP_LOAD;
      end
      (opc == OPC_BRANCH): begin
        dec.branch = 1'b1;
        dec.aluop  = ALUOP_BRANCH;
      end
      (opc == OPC_JAL): begin
        dec.jal   = 1'b1;
        dec.aluop = ALUOP_JUMP;
      end
      (opc == OPC_JALR): begin
        dec.jalr  = 1'b1;
        dec.aluop = ALUOP_JUMP;
      end
      (opc == OPC_LUI): begin
        dec.lui   = 1'b1;
        dec.aluop = ALUOP_LUI;
      end
      default: begin
        dec.aluop   = ALUOP_ILLEGAL;
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_type_decoder.sv
// Decode front end: opcode classify into a 2-entry skid buffer.
// INSTR_TYPE_DECODER_PERF_CNT_EN adds a legal-instruction counter.
module instr_type_decoder
  import decoder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  instr_type_decoder_if.slave bus
);

  if (XLEN != INSTR_W) begin : g_xlen_check
    $error("instr_type_decoder supports XLEN=32 only");
  end

  buf_state_e state;
  dec_t       dec_in;
  dec_t       out_q;
  dec_t       skid_q;
  dec_t       out_d;
  logic       ready;
  logic       valid;
  logic       in_xfer;
  logic       out_xfer;

  opcode_classify u_classify (
    .instr (bus.instr_i),
    .dec   (dec_in)
  );

  assign ready    = (state != FULL);
  assign valid    = (state != EMPTY);
  assign in_xfer  = bus.instr_valid_i && ready;
  assign out_xfer = valid && bus.out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else if (bus.flush_i) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_q <= dec_in;
            state <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_q <= dec_in;
          end else if (in_xfer) begin
            skid_q <= dec_in;
            state  <= FULL;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            out_q <= skid_q;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Stale register contents never leak out while nothing is presented
  assign out_d = valid ? out_q : '0;

  assign bus.instr_ready_o = ready;
  assign bus.out_valid_o   = valid;
  assign bus.instr_o       = out_d.instr;
  assign bus.r_type_o      = out_d.r_type;
  assign bus.i_type_o      = out_d.i_type;
  assign bus.store_o       = out_d.store;
  assign bus.load_o        = out_d.load;
  assign bus.branch_o      = out_d.branch;
  assign bus.jal_o         = out_d.jal;
  assign bus.jalr_o        = out_d.jalr;
  assign bus.lui_o         = out_d.lui;
  assign bus.aluop_o       = out_d.aluop;
  assign bus.illegal_o     = out_d.illegal;

`ifdef INSTR_TYPE_DECODER_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (out_xfer && !out_q.illegal) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_cnt_o = perf_q;
`else
  assign bus.perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_instr_type_decoder.sv
// Scoreboard bench for instr_type_decoder.
// Driver queues expected results on acceptance; monitor pops on output.
module tb_instr_type_decoder;
  import decoder_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  typ;
    logic [2:0]  aluop;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   legal_seen = 0;
  int   cyc = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  instr_type_decoder_if bus();

  instr_type_decoder #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  wire [7:0] typ_o = {bus.r_type_o, bus.i_type_o, bus.store_o,
                      bus.load_o, bus.branch_o, bus.jal_o,
                      bus.jalr_o, bus.lui_o};

  // Hand-computed vectors: {word, strobes r,i,st,ld,br,jal,jalr,lui, aluop, illegal}
  localparam exp_t V_ADD  = '{32'h003100B3, 8'b1000_0000, 3'b000, 1'b0};
  localparam exp_t V_ADDI = '{32'h00108093, 8'b0100_0000, 3'b001, 1'b0};
  localparam exp_t V_SW   = '{32'h0010A023, 8'b0010_0000, 3'b101, 1'b0};
  localparam exp_t V_LW   = '{32'h0000A083, 8'b0001_0000, 3'b100, 1'b0};
  localparam exp_t V_BEQ  = '{32'h00208063, 8'b0000_1000, 3'b010, 1'b0};
  localparam exp_t V_JAL  = '{32'h008000EF, 8'b0000_0100, 3'b011, 1'b0};
  localparam exp_t V_JALR = '{32'h000080E7, 8'b0000_0010, 3'b011, 1'b0};
  localparam exp_t V_LUI  = '{32'h123450B7, 8'b0000_0001, 3'b110, 1'b0};
  localparam exp_t V_ILL  = '{32'h0000007F, 8'b0000_0000, 3'b111, 1'b1};
  localparam exp_t V_LUI2 = '{32'h0ABCD0B7, 8'b0000_0001, 3'b110, 1'b0};

`ifdef INSTR_TYPE_DECODER_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops on every output transfer, checks stall stability
  initial begin
    exp_t e;
    exp_t cur;
    exp_t prev;
    logic stall_prev;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        cur = '{bus.instr_o, typ_o, bus.aluop_o, bus.illegal_o};
        if (bus.out_valid_o) begin
          if (stall_prev) chk("stable", cur, prev);
          if (bus.out_ready_i) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out: got %0h want none",
                       bus.instr_o);
            end else begin
              e = q.pop_front();
              chk("instr", bus.instr_o, e.instr);
              chk("strobes", typ_o, e.typ);
              chk("aluop", bus.aluop_o, e.aluop);
              chk("illegal", bus.illegal_o, e.illegal);
              if (!e.illegal) legal_seen++;
            end
          end
        end else begin
          chk("idle_zero", {typ_o, bus.illegal_o}, 9'd0);
        end
        stall_prev = bus.out_valid_o && !bus.out_ready_i;
        prev = cur;
        if (bus.flush_i) q.delete();
      end
    end
  end

  task automatic send(input exp_t e);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    bus.instr_i = e.instr;
    bus.instr_valid_i = 1'b1;
    while (!acc && n <= 50) begin
      @(negedge clk);
      acc = bus.instr_ready_o && !bus.flush_i;
      @(posedge clk);
      if (acc) q.push_back(e);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got not_accepted want %0h", e.instr);
    end
    bus.instr_valid_i = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("drained", q.size(), 0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, bus.out_valid_o, 1'b0);
    chk({tag, "_ready"}, bus.instr_ready_o, 1'b1);
    chk({tag, "_instr"}, bus.instr_o, 32'd0);
    chk({tag, "_strb"}, {typ_o, bus.illegal_o}, 9'd0);
    chk({tag, "_aluop"}, bus.aluop_o, 3'b000);
    chk({tag, "_perf"}, bus.perf_cnt_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    exp_t list10[10];
    list10 = '{V_ADD, V_ADDI, V_SW, V_LW, V_BEQ,
               V_JAL, V_JALR, V_LUI, V_LUI2, V_ADD};
    bus.instr_i = '0;
    bus.instr_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add, one-cycle latency
    bus.out_ready_i = 1'b1;
    send(V_ADD);
    chk("add_valid", bus.out_valid_o, 1'b1);
    chk("add_rtype", bus.r_type_o, 1'b1);
    chk("add_aluop", bus.aluop_o, 3'b000);
    chk("add_illegal", bus.illegal_o, 1'b0);
    drain();

    // Back-to-back stream, one per cycle
    c0 = cyc;
    send(V_LW);
    send(V_SW);
    send(V_BEQ);
    send(V_JAL);
    send(V_LUI);
    chk("stream_cycles", cyc - c0, 5);
    drain();

    // Back-pressure into FULL, then release
    bus.out_ready_i = 1'b0;
    send(V_ADDI);
    chk("one_ready", bus.instr_ready_o, 1'b1);
    send(V_JALR);
    chk("full_ready", bus.instr_ready_o, 1'b0);
    chk("full_valid", bus.out_valid_o, 1'b1);
    bus.instr_i = V_ADD.instr;
    bus.instr_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("full_hold_ready", bus.instr_ready_o, 1'b0);
    chk("full_hold_head", bus.instr_o, V_ADDI.instr);
    bus.out_ready_i = 1'b1;
    send(V_ADD);
    drain();

    // Illegal opcode
    send(V_ILL);
    chk("ill_flag", bus.illegal_o, 1'b1);
    chk("ill_strb", typ_o, 8'd0);
    chk("ill_aluop", bus.aluop_o, 3'b111);
    drain();
    chk("perf_after_ill", bus.perf_cnt_o,
        PERF_ON ? 32'(legal_seen) : 32'd0);

    // Flush in FULL with a simultaneous input
    bus.out_ready_i = 1'b0;
    send(V_BEQ);
    send(V_LW);
    bus.instr_i = V_LUI2.instr;
    bus.instr_valid_i = 1'b1;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.instr_valid_i = 1'b0;
    chk("flush_valid", bus.out_valid_o, 1'b0);
    chk("flush_ready", bus.instr_ready_o, 1'b1);
    bus.out_ready_i = 1'b1;
    send(V_SW);
    drain();

    // Asynchronous reset while FULL
    bus.out_ready_i = 1'b0;
    send(V_JAL);
    send(V_ADDI);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("async_rst");
    q.delete();
    legal_seen = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ten legal transfers for the counter
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) send(list10[i]);
    drain();
    chk("perf_10", bus.perf_cnt_o, PERF_ON ? 32'd10 : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_type_decoder.md
Name: instr_type_decoder

Overview:
- Decode stage front end. Takes 32-bit RV32I instruction words from fetch over a valid/ready handshake.
- Classifies each word into the one-hot instruction-type strobes consumed by ALUop (r_type, i_type, store, load, branch, jal, jalr, lui), plus the matching 3-bit aluop.
- Results are registered through a 2-entry skid buffer, so back-pressure from the execute stage never drops or duplicates an instruction.

Parameters:
- XLEN, 32, instruction word width; only 32 is supported.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- instr_i  input  XLEN  instruction word from fetch.
- instr_valid_i  input  1  instr_i is valid.
- instr_ready_o  output  1  block can accept instr_i this cycle.
- flush_i  input  1  discard all buffered instructions (taken branch or jump).
- out_valid_o  output  1  decoded outputs are valid.
- out_ready_i  input  1  execute stage accepts the decoded outputs.
- instr_o  output  XLEN  the instruction word being presented.
- r_type_o, i_type_o, store_o, load_o, branch_o, jal_o, jalr_o, lui_o  output  1 each  one-hot type strobes.
- aluop_o  output  3  ALU op class.
- illegal_o  output  1  opcode not recognised.
- perf_cnt_o  output  32  decoded-instruction count (see Optional Feature).

Behaviour:
- Opcode decode uses instr[6:0]:
  - 0110011: r_type, aluop 000.
  - 0010011: i_type, aluop 001.
  - 0100011: store, aluop 101.
  - 0000011: load, aluop 100.
  - 1100011: branch, aluop 010.
  - 1101111: jal, aluop 011.
  - 1100111: jalr, aluop 011.
  - 0110111: lui, aluop 110.
  - Any other opcode: all strobes 0, aluop 111, illegal_o 1.
- At most one strobe is high at any time. All strobes and illegal_o are 0 whenever out_valid_o is 0.
- Handshakes:
  - Input transfer occurs when instr_valid_i && instr_ready_o.
  - Output transfer occurs when out_valid_o && out_ready_i.
- State machine (registered): EMPTY, ONE (output register holds one entry), FULL (output register plus skid register).
  - EMPTY: input transfer -> ONE.
  - ONE: input transfer only -> FULL. Output transfer only -> EMPTY. Both -> ONE, with the output register reloaded from the input.
  - FULL: output transfer -> ONE, skid entry moves into the output register. No input is accepted in FULL.
- Outputs:
  - instr_ready_o = (state != FULL). It is a registered function of state and never depends combinationally on out_ready_i.
  - out_valid_o = (state != EMPTY).
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1.
- Ordering: strict FIFO. No instruction is dropped or duplicated.
- Decode happens before the buffer. The skid register stores the decoded fields together with the word.
- Output fields stay stable while out_valid_o && !out_ready_i.
- Flush:
  - flush_i forces the state to EMPTY at the next edge and overrides any simultaneous input or output transfer. An instruction presented in the flush cycle is discarded.
  - An output transfer in the same cycle as flush_i still counts as consumed by execute.
- Reset, including reset asserted mid-transfer: state EMPTY, out_valid_o 0, instr_ready_o 1, instr_o 0, all strobes 0, aluop_o 000, illegal_o 0, perf_cnt_o 0.

Optional Feature:
- Macro: INSTR_TYPE_DECODER_PERF_CNT_EN.
- Defined: perf_cnt_o is a 32-bit counter that increments on every output transfer where illegal_o is 0. It wraps from 0xFFFFFFFF to 0, is cleared by reset, and is not cleared by flush.
- Not defined: perf_cnt_o is tied to 0 and no counter flops exist.

Decomposition:
- Shared package decoder_pkg holds:
  - opcode localparams (OPC_R, OPC_I, OPC_STORE, OPC_LOAD, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI).
  - aluop localparams (ALUOP_R=000 … ALUOP_ILLEGAL=111).
  - typedef enum for the buffer states.
  - packed struct dec_t {instr, 8 type bits, aluop, illegal}.
- One combinational sub-module, opcode_classify: instr[6:0] -> dec_t fields. It is instantiated once, on the input side.

Test Plan:
- Reset, then present 0x003100B3 (add) with out_ready_i=1 -> next cycle out_valid_o=1, r_type_o=1, aluop_o=000, illegal_o=0.
- Stream lw 0x0000A083, sw 0x0010A023, beq 0x00208063, jal 0x008000EF, lui 0x123450B7 back-to-back with out_ready_i=1 -> one result per cycle, in order, with aluop 100, 101, 010, 011, 110.
- Hold out_ready_i=0 while presenting 3 words -> instr_ready_o drops after the 2nd is accepted. Then raise out_ready_i -> both held entries emerge in order, then the 3rd is accepted with nothing lost.
- Present opcode 0x7F with out_ready_i=1 -> illegal_o=1, all strobes 0, aluop_o=111. With INSTR_TYPE_DECODER_PERF_CNT_EN defined, perf_cnt_o does not increment.
- In FULL, assert flush_i together with instr_valid_i -> next cycle out_valid_o=0, instr_ready_o=1, and the flush-cycle instruction never appears.
- Assert rst_ni low asynchronously mid-stream in FULL -> outputs clear immediately without waiting for a clock edge. With INSTR_TYPE_DECODER_PERF_CNT_EN, after 10 legal output transfers perf_cnt_o=10.
